// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered 4-op-class ALU responder behind a valid/ready
// request channel and a valid/ready response channel.
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_op/x/y/cin         opcode, operands, carry-in (latched at accept)
//   rsp_valid/rsp_ready    response handshake
//   rsp_result/cout/err    2W-bit result, carry/no-borrow, illegal-opcode flag
//   busy                   unit is not idle
// Logic/add/shift ops complete one edge after accept; MULT is a W-edge
// shift-add. Response fields hold their last value while idle.
module alu_exec_unit #(
    parameter int unsigned W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [W-1:0]    req_x,
    input  logic [W-1:0]    req_y,
    input  logic            req_cin,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*W-1:0]  rsp_result,
    output logic            rsp_cout,
    output logic            rsp_err,
    output logic            busy
);
    localparam int unsigned RW = 2 * W;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_XNOR = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_MULT = 4'b1010;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    state_t          state, state_n;
    logic [3:0]      op_q, op_n;
    logic [W-1:0]    x_q, x_n, y_q, y_n;
    logic            cin_q, cin_n;
    logic [RW-1:0]   acc_q, acc_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            ready_n, valid_n, busy_n, cout_n, err_n;
    logic [RW-1:0]   result_n;

    logic [W:0]      sum_w, diff_w;
    logic [W-1:0]    lo;
    logic [RW-1:0]   alu_res;
    logic            alu_cout, alu_err;

    // Single-cycle ALU on the latched operands; SUB uses x + ~y + 1 so the
    // carry out is the no-borrow flag.
    always_comb begin
        lo       = '0;
        alu_cout = 1'b0;
        alu_err  = 1'b0;
        sum_w    = {1'b0, x_q} + {1'b0, y_q} + (W+1)'(cin_q);
        diff_w   = {1'b0, x_q} + {1'b0, ~y_q} + (W+1)'(1);
        case (op_q)
            OP_AND:  lo = x_q & y_q;
            OP_NAND: lo = ~(x_q & y_q);
            OP_OR:   lo = x_q | y_q;
            OP_NOR:  lo = ~(x_q | y_q);
            OP_XOR:  lo = x_q ^ y_q;
            OP_XNOR: lo = ~(x_q ^ y_q);
            OP_NOT:  lo = ~x_q;
            OP_SHL:  lo = (32'(y_q) >= W) ? '0 : (x_q << y_q);
            OP_ADD:  begin lo = sum_w[W-1:0];  alu_cout = sum_w[W];  end
            OP_SUB:  begin lo = diff_w[W-1:0]; alu_cout = diff_w[W]; end
            default: alu_err = 1'b1;
        endcase
        alu_res = RW'(lo);
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_n  = state;
        op_n     = op_q;
        x_n      = x_q;
        y_n      = y_q;
        cin_n    = cin_q;
        acc_n    = acc_q;
        cnt_n    = cnt_q;
        result_n = rsp_result;
        cout_n   = rsp_cout;
        err_n    = rsp_err;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_n    = req_op;
                    x_n     = req_x;
                    y_n     = req_y;
                    cin_n   = req_cin;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = (req_op == OP_MULT) ? MUL : EXEC;
                end
            end
            EXEC: begin
                result_n = alu_res;
                cout_n   = alu_cout;
                err_n    = alu_err;
                state_n  = RESP;
            end
            MUL: begin
                if (y_q[cnt_q]) begin
                    acc_n = acc_q + (RW'(x_q) << cnt_q);
                end
                cnt_n = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    result_n = acc_n;
                    cout_n   = 1'b0;
                    err_n    = 1'b0;
                    state_n  = RESP;
                end
            end
            RESP: begin
                // rsp_valid is always high here, so rsp_ready alone completes.
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
        valid_n = (state_n == RESP);
        busy_n  = (state_n != IDLE);
    end

    // State and output registers; req_ready stays low through reset so it
    // first rises on the edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cin_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            x_q        <= x_n;
            y_q        <= y_n;
            cin_q      <= cin_n;
            acc_q      <= acc_n;
            cnt_q      <= cnt_n;
            req_ready  <= ready_n;
            rsp_valid  <= valid_n;
            rsp_result <= result_n;
            rsp_cout   <= cout_n;
            rsp_err    <= err_n;
            busy       <= busy_n;
        end
    end

endmodule
